// File: rtl/riscv_config_ctrl.sv
// UART-driven configuration controller for a small RISC-V core.
// Parses opcode + little-endian argument bytes from the receive stream,
// performs instruction/data/register writes and reads through strobed
// config ports, runs the core for a counted number of cycles, pulses the
// core reset, and answers over the transmit handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an opcode byte
// ARGS    | collecting argument bytes for the latched opcode
// SETUP   | address (and write data) driven, no strobe yet
// STROBE  | selected clkconfig high for one cycle / core reset pulse
// HOLD    | address and write data held one cycle after the strobe
// CAPTURE | read address still driven, read data latched at end of cycle
// SEND    | transmitting the 4 captured read bytes, LSB first
// RUN     | configon low, run counter counting down to terminal count
// ACK     | transmitting the single status byte (0xAA ack or 0xEE error)
module riscv_config_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        configon,
  output logic        core_rst_n,
  output logic [31:0] fetch_configaddr,
  output logic [31:0] fetch_writeinst,
  output logic        fetch_clkconfig,
  output logic [31:0] mem_configaddr,
  output logic [31:0] mem_writedata,
  output logic        mem_clkconfig,
  input  logic [31:0] mem_dataout,
  output logic [4:0]  reg_configaddr,
  output logic [31:0] reg_writedata,
  output logic        reg_clkconfig,
  input  logic [31:0] reg_dataout
);

  localparam logic [7:0] OP_WR_INST = 8'h01;
  localparam logic [7:0] OP_WR_DMEM = 8'h02;
  localparam logic [7:0] OP_WR_REG  = 8'h03;
  localparam logic [7:0] OP_RD_DMEM = 8'h04;
  localparam logic [7:0] OP_RD_REG  = 8'h05;
  localparam logic [7:0] OP_RUN     = 8'h06;
  localparam logic [7:0] OP_CORE_RST = 8'h07;

  localparam logic [7:0] BYTE_ACK = 8'hAA;
  localparam logic [7:0] BYTE_ERR = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARGS,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_CAPTURE,
    S_SEND,
    S_RUN,
    S_ACK
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  op_q, op_nx;
  logic [63:0] arg_q, arg_nx;
  logic [2:0]  arg_cnt_q, arg_cnt_nx;
  logic [31:0] run_cnt_q, run_cnt_nx;
  logic [31:0] cap_q, cap_nx;
  logic [1:0]  send_idx_q, send_idx_nx;
  logic [7:0]  ack_q, ack_nx;

  logic [2:0]  last_arg_idx;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] run_n;
  logic        is_read;

  // Index of the final argument byte for the latched opcode.
  always_comb begin
    last_arg_idx = 3'd0;
    case (op_q)
      OP_WR_INST, OP_WR_DMEM: last_arg_idx = 3'd7;
      OP_WR_REG:              last_arg_idx = 3'd4;
      OP_RD_DMEM, OP_RUN:     last_arg_idx = 3'd3;
      OP_RD_REG:              last_arg_idx = 3'd0;
      default:                last_arg_idx = 3'd0;
    endcase
  end

  // Register commands carry a one-byte address, so data starts at byte 1.
  assign cmd_addr = (op_q == OP_WR_REG || op_q == OP_RD_REG) ? {24'd0, arg_q[7:0]} : arg_q[31:0];
  assign cmd_data = (op_q == OP_WR_REG) ? arg_q[39:8] : arg_q[63:32];
  assign is_read  = (op_q == OP_RD_DMEM) || (op_q == OP_RD_REG);

  // Run count as it will be once the top byte arriving now is included.
  assign run_n = {rx_data, arg_q[23:0]};

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= 8'd0;
      arg_q      <= 64'd0;
      arg_cnt_q  <= 3'd0;
      run_cnt_q  <= 32'd0;
      cap_q      <= 32'd0;
      send_idx_q <= 2'd0;
      ack_q      <= 8'd0;
    end else begin
      state      <= state_nx;
      op_q       <= op_nx;
      arg_q      <= arg_nx;
      arg_cnt_q  <= arg_cnt_nx;
      run_cnt_q  <= run_cnt_nx;
      cap_q      <= cap_nx;
      send_idx_q <= send_idx_nx;
      ack_q      <= ack_nx;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nx    = state;
    op_nx       = op_q;
    arg_nx      = arg_q;
    arg_cnt_nx  = arg_cnt_q;
    run_cnt_nx  = run_cnt_q;
    cap_nx      = cap_q;
    send_idx_nx = send_idx_q;
    ack_nx      = ack_q;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          op_nx      = rx_data;
          arg_nx     = 64'd0;
          arg_cnt_nx = 3'd0;
          ack_nx     = BYTE_ACK;
          if (rx_data == OP_CORE_RST) begin
            state_nx = S_STROBE;
          end else if (rx_data >= OP_WR_INST && rx_data <= OP_RUN) begin
            state_nx = S_ARGS;
          end else begin
            ack_nx   = BYTE_ERR;
            state_nx = S_ACK;
          end
        end
      end
      S_ARGS: begin
        if (rx_valid) begin
          arg_nx[{arg_cnt_q, 3'b000} +: 8] = rx_data;
          arg_cnt_nx = arg_cnt_q + 3'd1;
          if (arg_cnt_q == last_arg_idx) begin
            if (op_q == OP_RUN) begin
              // A zero count skips RUN so configon never drops.
              if (run_n == 32'd0) begin
                state_nx = S_ACK;
              end else begin
                run_cnt_nx = run_n;
                state_nx   = S_RUN;
              end
            end else begin
              state_nx = S_SETUP;
            end
          end
        end
      end
      S_SETUP: begin
        state_nx = is_read ? S_CAPTURE : S_STROBE;
      end
      S_STROBE: begin
        state_nx = (op_q == OP_CORE_RST) ? S_ACK : S_HOLD;
      end
      S_HOLD: begin
        state_nx = S_ACK;
      end
      S_CAPTURE: begin
        cap_nx      = (op_q == OP_RD_REG) ? reg_dataout : mem_dataout;
        send_idx_nx = 2'd0;
        state_nx    = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (send_idx_q == 2'd3) begin
            state_nx = S_IDLE;
          end else begin
            send_idx_nx = send_idx_q + 2'd1;
          end
        end
      end
      S_RUN: begin
        // Entered holding N; terminal count 1 ends the window after N cycles.
        if (run_cnt_q == 32'd1) begin
          state_nx = S_ACK;
        end else begin
          run_cnt_nx = run_cnt_q - 32'd1;
        end
      end
      S_ACK: begin
        if (tx_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode; reset forces the idle values combinationally.
  always_comb begin
    tx_data          = 8'd0;
    tx_valid         = 1'b0;
    configon         = 1'b1;
    core_rst_n       = 1'b1;
    fetch_configaddr = 32'd0;
    fetch_writeinst  = 32'd0;
    fetch_clkconfig  = 1'b0;
    mem_configaddr   = 32'd0;
    mem_writedata    = 32'd0;
    mem_clkconfig    = 1'b0;
    reg_configaddr   = 5'd0;
    reg_writedata    = 32'd0;
    reg_clkconfig    = 1'b0;
    if (!rst) begin
      core_rst_n = 1'b0;
    end else begin
      if (state inside {S_SETUP, S_STROBE, S_HOLD, S_CAPTURE}) begin
        case (op_q)
          OP_WR_INST: begin
            fetch_configaddr = cmd_addr;
            fetch_writeinst  = cmd_data;
            fetch_clkconfig  = (state == S_STROBE);
          end
          OP_WR_DMEM: begin
            mem_configaddr = cmd_addr;
            mem_writedata  = cmd_data;
            mem_clkconfig  = (state == S_STROBE);
          end
          OP_WR_REG: begin
            reg_configaddr = cmd_addr[4:0];
            reg_writedata  = cmd_data;
            reg_clkconfig  = (state == S_STROBE);
          end
          OP_RD_DMEM: begin
            mem_configaddr = cmd_addr;
          end
          OP_RD_REG: begin
            reg_configaddr = cmd_addr[4:0];
          end
          OP_CORE_RST: begin
            core_rst_n = (state != S_STROBE);
          end
          default: begin
            core_rst_n = 1'b1;
          end
        endcase
      end
      case (state)
        S_SEND: begin
          tx_valid = 1'b1;
          tx_data  = cap_q[{send_idx_q, 3'b000} +: 8];
        end
        S_RUN: begin
          configon = 1'b0;
        end
        S_ACK: begin
          tx_valid = 1'b1;
          tx_data  = ack_q;
        end
        default: begin
          tx_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_config_ctrl.md
RISCV_CONFIG_CTRL -- requirements
Module: riscv_config_ctrl

Interface
REQ-001 The block SHALL have clk  input  1  system clock, shared with the core; all logic on the rising edge.
REQ-002 The block SHALL have rst  input  1  reset, synchronous, active-low.
REQ-003 The block SHALL have rx_data  input  8  and rx_valid  input  1: UART receive byte, with a 1-cycle valid pulse per byte.
REQ-004 The block SHALL have tx_data  output  8, tx_valid  output  1 and tx_ready  input  1: UART transmit byte handshake.
REQ-005 The block SHALL have configon  output  1: the core is in config mode while this is high.
REQ-006 The block SHALL have core_rst_n  output  1: active-low core reset.
REQ-007 The block SHALL have fetch_configaddr  output  32, fetch_writeinst  output  32 and fetch_clkconfig  output  1: instruction memory write port.
REQ-008 The block SHALL have mem_configaddr  output  32, mem_writedata  output  32, mem_clkconfig  output  1 and mem_dataout  input  32: data memory port.
REQ-009 The block SHALL have reg_configaddr  output  5, reg_writedata  output  32, reg_clkconfig  output  1 and reg_dataout  input  32: register file port.

Function
REQ-010 The block SHALL parse commands as an opcode byte followed by argument bytes; all multi-byte fields are little-endian.
REQ-011 Opcodes SHALL be:
- 0x01 write instruction: addr32, data32.
- 0x02 write data memory: addr32, data32.
- 0x03 write register: addr8 (bits 4:0 used), data32.
- 0x04 read data memory: addr32.
- 0x05 read register: addr8.
- 0x06 run: count32.
- 0x07 core reset: no arguments.
REQ-012 States SHALL be IDLE, ARGS, SETUP, STROBE, HOLD, CAPTURE, SEND, RUN and ACK.
- IDLE -> ARGS on a valid opcode.
- ARGS -> next state once the last argument byte is received.
REQ-013 Writes SHALL proceed as follows:
- SETUP: address and data are driven.
- STROBE: the selected clkconfig is high for exactly 1 cycle.
- HOLD: address and data are held one more cycle.
- Then ACK.
- Address and data SHALL be stable from SETUP through HOLD.
REQ-014 Reads SHALL proceed as follows:
- SETUP: drive the address.
- CAPTURE: latch mem_dataout or reg_dataout one cycle after the address is valid.
- SEND: transmit the 4 captured bytes, LSB first.
REQ-015 Run SHALL behave as follows:
- Count N != 0: configon is low for exactly N consecutive cycles, then returns high, then ACK.
- N = 0: configon is not deasserted; go directly to ACK.
REQ-016 Core reset SHALL drive core_rst_n low for exactly 1 cycle, then go to ACK.
REQ-017 ACK SHALL transmit the single byte 0xAA.
REQ-018 An unknown opcode SHALL transmit 0xEE and return to IDLE without consuming further bytes.
REQ-019 Transmit handshake: tx_data SHALL be stable while tx_valid is high; a byte is transferred on a cycle with tx_valid and tx_ready both high; tx_valid SHALL deassert or advance to the next byte on the following cycle.
REQ-020 rx_valid bytes arriving outside IDLE and ARGS SHALL be dropped.
REQ-021 At most one clkconfig output SHALL be high in any cycle, and only while configon is high.
REQ-022 The run counter SHALL be 32-bit and count down; N = 0xFFFFFFFF SHALL be honoured without wrap.
REQ-023 After every completed command the block SHALL return to IDLE with configon high.

Reset
REQ-024 While rst is low, the block SHALL force:
- state to IDLE;
- configon high and core_rst_n low;
- all clkconfig outputs and tx_valid low;
- all address, data and tx_data outputs to 0.
REQ-025 After rst goes high, core_rst_n SHALL be high from the next cycle.
REQ-026 rst asserted mid-command, including during RUN or SEND, SHALL abort the command immediately with no ack byte.

Verification
REQ-027 Bytes 01 08 00 00 00 13 05 A0 00 -> fetch_configaddr=0x8 and fetch_writeinst=0x00A00513 stable for 3 cycles; fetch_clkconfig high for 1 cycle; 0xAA sent.
REQ-028 Bytes 03 05 EF BE AD DE, then 05 05 (bench models a register file) -> reg_clkconfig pulse with reg_configaddr=5; 0xAA; then bytes EF BE AD DE sent.
REQ-029 Bytes 06 0A 00 00 00 -> configon low for exactly 10 cycles, then 0xAA; 06 00 00 00 00 -> configon never low, 0xAA.
REQ-030 Bytes 02 10 00 00 00 11 22 33 44 with tx_ready held low for 20 cycles -> tx_valid=1 and tx_data=0xAA held until tx_ready rises; exactly one transfer.
REQ-031 Opcode 0x5A -> 0xEE sent, state IDLE; the following 07 -> core_rst_n low for 1 cycle, 0xAA.
REQ-032 rst asserted on the 3rd cycle of a 100-cycle run -> configon high on the next cycle, no 0xAA, next command accepted normally.
